// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: canonical NOP and instruction-memory mode.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package riscv_pkg;

    // addi x0,x0,0 -- also driven by the pipeline flush logic
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-serial program loader: RUN/LOAD mode FSM, little-endian word assembly, write pointer.
// Latency: memory write issued combinationally in the cycle that accepts the completing byte or stop.
// Backpressure: none; bytes arriving once DEPTH words are written are dropped and flagged.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_start,
    input  logic                      ld_byte_valid,
    input  logic [7:0]                ld_byte,
    input  logic                      ld_stop,
    output logic                      ld_busy,
    output logic                      ld_done,
    output logic                      ld_overflow,
    output logic [$clog2(DEPTH):0]    ld_words,
    output logic                      we,
    output logic [$clog2(DEPTH)-1:0]  waddr,
    output logic [31:0]               wdata
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    imem_state_t state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [AW:0] ptr_q, ptr_d;
    logic [23:0] buf_q, buf_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    // Next-state: restart/enter load, consume a byte, then honour stop (partial word flush)
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        ptr_d   = ptr_q;
        buf_d   = buf_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        we      = 1'b0;
        wdata   = 32'h0;
        if (ld_start) begin
            // start overrides stop and any byte in the same cycle
            state_d = LOAD;
            lane_d  = 2'd0;
            ptr_d   = '0;
            buf_d   = 24'h0;
            ovf_d   = 1'b0;
        end else if (state_q == LOAD) begin
            if (ld_byte_valid) begin
                if (ptr_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    case (lane_q)
                        // lane 0 clears the upper lanes so a short word is zero-filled
                        2'd0: begin buf_d = {16'h0, ld_byte}; lane_d = 2'd1; end
                        2'd1: begin buf_d[15:8]  = ld_byte;   lane_d = 2'd2; end
                        2'd2: begin buf_d[23:16] = ld_byte;   lane_d = 2'd3; end
                        default: begin
                            we     = 1'b1;
                            wdata  = {ld_byte, buf_q};
                            ptr_d  = ptr_q + ONE;
                            lane_d = 2'd0;
                        end
                    endcase
                end
            end
            if (ld_stop) begin
                // a partial word can only exist while the pointer is below DEPTH
                if (lane_d != 2'd0) begin
                    we    = 1'b1;
                    wdata = {8'h00, buf_d};
                    ptr_d = ptr_d + ONE;
                end
                lane_d  = 2'd0;
                state_d = RUN;
                done_d  = 1'b1;
            end
        end
        // nothing reaches memory during reset; a half-built word is simply lost
        if (!rst_n) we = 1'b0;
    end

    // Loader state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            lane_q  <= 2'd0;
            ptr_q   <= '0;
            buf_q   <= 24'h0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            ptr_q   <= ptr_d;
            buf_q   <= buf_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // the write pointer doubles as the written-word count
    assign waddr       = ptr_q[AW-1:0];
    assign ld_words    = ptr_q;
    assign ld_busy     = (state_q == LOAD);
    assign ld_done     = done_q;
    assign ld_overflow = ovf_q;

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory with registered fetch port and byte-serial program loader.
// Latency: 1 cycle from accepted fetch address to instr_out.
// Backpressure: stall holds all fetch outputs; flush and load mode force a NOP.
module imem_sync #(
    parameter int          DEPTH     = 256,
    parameter string       INIT_FILE = "",
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_en,
    input  logic [31:0]             fetch_addr,
    input  logic                    stall,
    input  logic                    flush,
    output logic [31:0]             instr_out,
    output logic                    instr_valid,
    output logic                    fetch_fault,
    input  logic                    ld_start,
    input  logic                    ld_byte_valid,
    input  logic [7:0]              ld_byte,
    input  logic                    ld_stop,
    output logic                    ld_busy,
    output logic                    ld_done,
    output logic                    ld_overflow,
    output logic [$clog2(DEPTH):0]  ld_words
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_q;
    logic          valid_q;
    logic          fault_q;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          run;
    logic          bad_addr;
    logic          hit;

    imem_loader #(.DEPTH(DEPTH)) u_loader (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_start      (ld_start),
        .ld_byte_valid (ld_byte_valid),
        .ld_byte       (ld_byte),
        .ld_stop       (ld_stop),
        .ld_busy       (ld_busy),
        .ld_done       (ld_done),
        .ld_overflow   (ld_overflow),
        .ld_words      (ld_words),
        .we            (we),
        .waddr         (waddr),
        .wdata         (wdata)
    );

    assign run      = !ld_busy;
    assign bad_addr = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:2] >= 30'(DEPTH));
    assign hit      = run && fetch_en && !stall && !flush && !bad_addr;

    // Loader write port; no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port; only a good accepted fetch updates it, so it holds across stalls
    always_ff @(posedge clk) begin
        if (hit) rd_q <= mem[fetch_addr[AW+1:2]];
    end

    // Fetch status: flush > stall > fetch; load mode always squashes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (!run || flush) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= fetch_en && !bad_addr;
            fault_q <= fetch_en && bad_addr;
        end
    end

    // gate with run so the first LOAD cycle never shows a fetch accepted on the start edge
    assign instr_valid = valid_q && run;
    assign fetch_fault = fault_q && run;
    assign instr_out   = instr_valid ? rd_q : NOP_INSTR;

endmodule

// File: tb/tb_imem_sync.sv
module tb_imem_sync;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        ld_start = 1'b0, ld_byte_valid = 1'b0, ld_stop = 1'b0;
    logic [7:0]  ld_byte = 8'h0;
    logic [31:0] instr_out;
    logic        instr_valid, fetch_fault, ld_busy, ld_done, ld_overflow;
    logic [8:0]  ld_words;

    logic        s_fetch_en = 1'b0, s_stall = 1'b0, s_flush = 1'b0;
    logic [31:0] s_fetch_addr = 32'h0;
    logic        s_ld_start = 1'b0, s_ld_byte_valid = 1'b0, s_ld_stop = 1'b0;
    logic [7:0]  s_ld_byte = 8'h0;
    logic [31:0] s_instr_out;
    logic        s_instr_valid, s_fetch_fault, s_ld_busy, s_ld_done, s_ld_overflow;
    logic [2:0]  s_ld_words;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [256];

    always #5 clk = ~clk;

    imem_sync #(.DEPTH(256)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .stall(stall), .flush(flush), .instr_out(instr_out), .instr_valid(instr_valid),
        .fetch_fault(fetch_fault), .ld_start(ld_start), .ld_byte_valid(ld_byte_valid),
        .ld_byte(ld_byte), .ld_stop(ld_stop), .ld_busy(ld_busy), .ld_done(ld_done),
        .ld_overflow(ld_overflow), .ld_words(ld_words)
    );

    imem_sync #(.DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .fetch_en(s_fetch_en), .fetch_addr(s_fetch_addr),
        .stall(s_stall), .flush(s_flush), .instr_out(s_instr_out), .instr_valid(s_instr_valid),
        .fetch_fault(s_fetch_fault), .ld_start(s_ld_start), .ld_byte_valid(s_ld_byte_valid),
        .ld_byte(s_ld_byte), .ld_stop(s_ld_stop), .ld_busy(s_ld_busy), .ld_done(s_ld_done),
        .ld_overflow(s_ld_overflow), .ld_words(s_ld_words)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: what one accepted fetch of address a must return (DEPTH 256)
    function automatic void model_fetch(input logic [31:0] a, output logic [31:0] d,
                                        output logic v, output logic f);
        if (a[1:0] != 2'b00 || a[31:2] >= 30'd256) begin
            d = NOP; v = 1'b0; f = 1'b1;
        end else begin
            d = model_mem[a[9:2]]; v = 1'b1; f = 1'b0;
        end
    endfunction

    // full load on the big instance with random idle gaps; checks busy, done pulse, word count
    task automatic do_load(input logic [7:0] bytes[$], input bit stop_with_last);
        int n = bytes.size();
        int exp_words;
        for (int i = 0; i < n; i++) begin
            int w = i / 4;
            if (w < 256) begin
                if (i % 4 == 0) model_mem[w] = 32'h0;
                model_mem[w][8*(i%4) +: 8] = bytes[i];
            end
        end
        exp_words = ((n + 3) / 4 > 256) ? 256 : (n + 3) / 4;
        fetch_en = 1'b0;
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        n_cmp++;
        if (ld_busy !== 1'b1) begin n_bad++; $display("FAIL load_busy: got %b want 1", ld_busy); end
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin ld_byte_valid = 1'b0; tick(); end
            ld_byte_valid = 1'b1;
            ld_byte = bytes[i];
            if (stop_with_last && i == n - 1) ld_stop = 1'b1;
            tick();
        end
        ld_byte_valid = 1'b0;
        if (!(stop_with_last && n > 0)) begin ld_stop = 1'b1; tick(); end
        ld_stop = 1'b0;
        n_cmp++;
        if ({ld_done, ld_busy} !== 2'b10) begin
            n_bad++; $display("FAIL load_done: got done=%b busy=%b want done=1 busy=0", ld_done, ld_busy);
        end
        n_cmp++;
        if (ld_words !== 9'(exp_words)) begin
            n_bad++; $display("FAIL load_words: got %0d want %0d", ld_words, exp_words);
        end
        tick();
        n_cmp++;
        if (ld_done !== 1'b0) begin n_bad++; $display("FAIL load_done_pulse: got %b want 0", ld_done); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(); tick();
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {NOP, 2'b00}) begin
            n_bad++; $display("FAIL reset_fetch: got %h/%b/%b want %h/0/0", instr_out, instr_valid, fetch_fault, NOP);
        end
        n_cmp++;
        if ({ld_busy, ld_done, ld_overflow, ld_words} !== 12'h0) begin
            n_bad++; $display("FAIL reset_loader: got busy=%b done=%b ovf=%b words=%0d want all 0",
                              ld_busy, ld_done, ld_overflow, ld_words);
        end
        n_cmp++;
        if ({s_instr_out, s_ld_busy, s_ld_overflow, s_ld_words} !== {NOP, 5'h0}) begin
            n_bad++; $display("FAIL reset_small: got %h busy=%b ovf=%b words=%0d", s_instr_out, s_ld_busy, s_ld_overflow, s_ld_words);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_basic();
        logic [7:0] q[$] = '{8'h13, 8'h03, 8'h00, 8'h08, 8'hAA};
        do_load(q, 1'b0);
        fetch_en = 1'b1; fetch_addr = 32'h0; tick();
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {32'h0800_0313, 2'b10}) begin
            n_bad++; $display("FAIL basic_word0: got %h/%b/%b want 08000313/1/0", instr_out, instr_valid, fetch_fault);
        end
        fetch_addr = 32'h4; tick();
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {32'h0000_00AA, 2'b10}) begin
            n_bad++; $display("FAIL basic_word1: got %h/%b/%b want 000000aa/1/0", instr_out, instr_valid, fetch_fault);
        end
        fetch_en = 1'b0;
    endtask

    // 8 words (word 5 = 405101b3) plus 2-byte tail, tail byte arriving with stop
    task automatic test_load_program();
        logic [7:0] q[$];
        logic [31:0] w;
        logic [31:0] ed;
        logic ev, ef;
        for (int i = 0; i < 8; i++) begin
            w = (i == 5) ? 32'h4051_01b3 : $urandom;
            for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
        end
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        do_load(q, 1'b1);
        fetch_en = 1'b1; fetch_addr = 32'h14; tick();
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {32'h4051_01b3, 2'b10}) begin
            n_bad++; $display("FAIL prog_word5: got %h/%b/%b want 405101b3/1/0", instr_out, instr_valid, fetch_fault);
        end
        fetch_addr = 32'h20; tick();
        model_fetch(32'h20, ed, ev, ef);
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {ed, ev, ef} || instr_out[31:16] !== 16'h0) begin
            n_bad++; $display("FAIL prog_partial: got %h/%b/%b want %h/%b/%b", instr_out, instr_valid, fetch_fault, ed, ev, ef);
        end
        fetch_en = 1'b0; tick();
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {NOP, 2'b00}) begin
            n_bad++; $display("FAIL idle_nop: got %h/%b/%b want %h/0/0", instr_out, instr_valid, fetch_fault, NOP);
        end
    endtask

    task automatic test_faults();
        fetch_en = 1'b1; fetch_addr = 32'h16; tick();
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {NOP, 2'b01}) begin
            n_bad++; $display("FAIL misalign: got %h/%b/%b want %h/0/1", instr_out, instr_valid, fetch_fault, NOP);
        end
        fetch_addr = 32'h400; tick();
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {NOP, 2'b01}) begin
            n_bad++; $display("FAIL out_of_range: got %h/%b/%b want %h/0/1", instr_out, instr_valid, fetch_fault, NOP);
        end
        fetch_addr = 32'h3FC; tick();
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} === {NOP, 2'b01} || instr_valid !== 1'b1) begin
            n_bad++; $display("FAIL last_word: got %h/%b/%b want valid=1 fault=0", instr_out, instr_valid, fetch_fault);
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_stall_flush();
        logic [31:0] ed;
        logic ev, ef;
        fetch_en = 1'b1; fetch_addr = 32'h14; tick();
        stall = 1'b1; fetch_addr = 32'h18;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({instr_out, instr_valid, fetch_fault} !== {32'h4051_01b3, 2'b10}) begin
                n_bad++; $display("FAIL stall_hold%0d: got %h/%b/%b want 405101b3/1/0", i, instr_out, instr_valid, fetch_fault);
            end
        end
        stall = 1'b0; flush = 1'b1; tick();
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {NOP, 2'b00}) begin
            n_bad++; $display("FAIL flush: got %h/%b/%b want %h/0/0", instr_out, instr_valid, fetch_fault, NOP);
        end
        flush = 1'b0; fetch_addr = 32'h16; tick();
        stall = 1'b1; fetch_addr = 32'h0; tick();
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {NOP, 2'b01}) begin
            n_bad++; $display("FAIL stall_fault_hold: got %h/%b/%b want %h/0/1", instr_out, instr_valid, fetch_fault, NOP);
        end
        stall = 1'b0; fetch_addr = 32'h18; tick();
        model_fetch(32'h18, ed, ev, ef);
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {ed, ev, ef}) begin
            n_bad++; $display("FAIL unstall: got %h/%b/%b want %h/%b/%b", instr_out, instr_valid, fetch_fault, ed, ev, ef);
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_random_fetch();
        logic [31:0] ed = NOP;
        logic ev = 1'b0, ef = 1'b0;
        logic [31:0] a;
        int r;
        fetch_en = 1'b0; stall = 1'b0; flush = 1'b0; tick();
        repeat (300) begin
            fetch_en = ($urandom_range(0, 9) < 8);
            stall    = ($urandom_range(0, 9) < 2);
            flush    = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 9);
            if (r == 0)      a = {$urandom_range(0, 8), 2'b00} + 32'($urandom_range(1, 3));
            else if (r == 1) a = {$urandom_range(256, 1 << 20), 2'b00};
            else             a = {$urandom_range(0, 8), 2'b00};
            fetch_addr = a;
            tick();
            if (flush)         begin ed = NOP; ev = 1'b0; ef = 1'b0; end
            else if (stall)    begin end
            else if (fetch_en) model_fetch(a, ed, ev, ef);
            else               begin ed = NOP; ev = 1'b0; ef = 1'b0; end
            n_cmp++;
            if ({instr_out, instr_valid, fetch_fault} !== {ed, ev, ef}) begin
                n_bad++; $display("FAIL random_fetch addr=%h en=%b st=%b fl=%b: got %h/%b/%b want %h/%b/%b",
                                  a, fetch_en, stall, flush, instr_out, instr_valid, fetch_fault, ed, ev, ef);
            end
        end
        fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    // restart and same-cycle start/stop during LOAD; fetches stay squashed while loading
    task automatic test_restart();
        logic [31:0] ed;
        logic ev, ef;
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        fetch_en = 1'b1; fetch_addr = 32'h0;
        ld_byte_valid = 1'b1; ld_byte = 8'h55; tick(); tick();
        ld_byte_valid = 1'b0;
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {NOP, 2'b00}) begin
            n_bad++; $display("FAIL load_squash: got %h/%b/%b want %h/0/0", instr_out, instr_valid, fetch_fault, NOP);
        end
        ld_start = 1'b1; ld_stop = 1'b1; tick();
        ld_start = 1'b0; ld_stop = 1'b0;
        n_cmp++;
        if ({ld_busy, ld_done, ld_words} !== {2'b10, 9'd0}) begin
            n_bad++; $display("FAIL start_wins: got busy=%b done=%b words=%0d want 1/0/0", ld_busy, ld_done, ld_words);
        end
        ld_stop = 1'b1; tick(); ld_stop = 1'b0;
        n_cmp++;
        if ({ld_busy, ld_done, ld_words} !== {2'b01, 9'd0}) begin
            n_bad++; $display("FAIL empty_stop: got busy=%b done=%b words=%0d want 0/1/0", ld_busy, ld_done, ld_words);
        end
        tick();
        model_fetch(32'h0, ed, ev, ef);
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {ed, ev, ef}) begin
            n_bad++; $display("FAIL restart_discard: got %h/%b/%b want %h/%b/%b", instr_out, instr_valid, fetch_fault, ed, ev, ef);
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] ed;
        logic ev, ef;
        logic [7:0] q[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_byte_valid = 1'b1; ld_byte = 8'hDE; tick();
        ld_byte = 8'hAD; tick();
        ld_byte_valid = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_cmp++;
        if ({ld_busy, ld_words, instr_out, instr_valid} !== {1'b0, 9'd0, NOP, 1'b0}) begin
            n_bad++; $display("FAIL midload_reset: got busy=%b words=%0d out=%h valid=%b", ld_busy, ld_words, instr_out, instr_valid);
        end
        fetch_en = 1'b1; fetch_addr = 32'h0; tick();
        model_fetch(32'h0, ed, ev, ef);
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {ed, ev, ef}) begin
            n_bad++; $display("FAIL midload_nowrite: got %h/%b/%b want %h/%b/%b", instr_out, instr_valid, fetch_fault, ed, ev, ef);
        end
        do_load(q, 1'b0);
        fetch_en = 1'b1; fetch_addr = 32'h0; tick();
        n_cmp++;
        if ({instr_out, instr_valid} !== {32'h4433_2211, 1'b1}) begin
            n_bad++; $display("FAIL reload_word0: got %h/%b want 44332211/1", instr_out, instr_valid);
        end
        fetch_addr = 32'h4; tick();
        model_fetch(32'h4, ed, ev, ef);
        n_cmp++;
        if ({instr_out, instr_valid, fetch_fault} !== {ed, ev, ef}) begin
            n_bad++; $display("FAIL reload_word1: got %h/%b/%b want %h/%b/%b", instr_out, instr_valid, fetch_fault, ed, ev, ef);
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] b [18];
        logic [31:0] w3, w0;
        for (int i = 0; i < 18; i++) b[i] = 8'($urandom);
        w0 = {b[3], b[2], b[1], b[0]};
        w3 = {b[15], b[14], b[13], b[12]};
        s_ld_start = 1'b1; tick(); s_ld_start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            s_ld_byte_valid = 1'b1; s_ld_byte = b[i]; tick();
        end
        s_ld_byte_valid = 1'b0;
        s_ld_stop = 1'b1; tick(); s_ld_stop = 1'b0;
        n_cmp++;
        if ({s_ld_done, s_ld_words, s_ld_overflow} !== {1'b1, 3'd4, 1'b1}) begin
            n_bad++; $display("FAIL overflow: got done=%b words=%0d ovf=%b want 1/4/1", s_ld_done, s_ld_words, s_ld_overflow);
        end
        s_fetch_en = 1'b1; s_fetch_addr = 32'hC; tick();
        n_cmp++;
        if ({s_instr_out, s_instr_valid} !== {w3, 1'b1}) begin
            n_bad++; $display("FAIL ovf_word3: got %h/%b want %h/1", s_instr_out, s_instr_valid, w3);
        end
        s_fetch_addr = 32'h0; tick();
        n_cmp++;
        if ({s_instr_out, s_instr_valid} !== {w0, 1'b1}) begin
            n_bad++; $display("FAIL ovf_word0: got %h/%b want %h/1 (dropped bytes must not wrap)", s_instr_out, s_instr_valid, w0);
        end
        s_fetch_addr = 32'h10; tick();
        n_cmp++;
        if ({s_instr_out, s_instr_valid, s_fetch_fault} !== {NOP, 2'b01}) begin
            n_bad++; $display("FAIL small_range: got %h/%b/%b want %h/0/1", s_instr_out, s_instr_valid, s_fetch_fault, NOP);
        end
        s_fetch_en = 1'b0;
        n_cmp++;
        if (s_ld_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", s_ld_overflow); end
        s_ld_start = 1'b1; tick(); s_ld_start = 1'b0;
        n_cmp++;
        if ({s_ld_busy, s_ld_overflow, s_ld_words} !== {2'b10, 3'd0}) begin
            n_bad++; $display("FAIL ovf_clear: got busy=%b ovf=%b words=%0d want 1/0/0", s_ld_busy, s_ld_overflow, s_ld_words);
        end
        s_ld_stop = 1'b1; tick(); s_ld_stop = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_program();
        test_faults();
        test_stall_flush();
        test_random_fetch();
        test_restart();
        test_reset_mid_load();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
